// File: rtl/hdmi_rx_word_align.sv
// Per-lane TMDS word aligner: hunts the 20 bit offsets for control tokens,
// locks after a run of hits, and emits boundary-aligned symbol pairs.
module hdmi_rx_word_align #(
  parameter int unsigned SEARCH_CYCLES = 4096,
  parameter int unsigned LOCK_COUNT    = 8,
  parameter int unsigned LOSS_CYCLES   = 16384
) (
  input  logic        rx_clk,
  input  logic        rx_reset,
  input  logic [19:0] rx_parallel_data,
  input  logic        rx_data_valid,
  output logic [19:0] aligned_data,
  output logic        aligned_valid,
  output logic        locked,
  output logic [4:0]  offset,
  output logic        token_hit
);

  localparam int unsigned SearchW = $clog2(SEARCH_CYCLES);
  localparam int unsigned LossW   = $clog2(LOSS_CYCLES);
  localparam logic [SearchW-1:0] SearchLast = SearchW'(SEARCH_CYCLES - 1);
  localparam logic [LossW-1:0]   LossLast   = LossW'(LOSS_CYCLES - 1);
  localparam logic [7:0]         LockLast   = 8'(LOCK_COUNT - 1);

  typedef enum logic {StHunt, StLocked} state_e;

  state_e               state_q, state_d;
  logic [4:0]           offset_q, offset_d, offset_next;
  logic [SearchW-1:0]   search_cnt_q, search_cnt_d;
  logic [7:0]           hit_cnt_q, hit_cnt_d;
  logic [LossW-1:0]     loss_cnt_q, loss_cnt_d;
  logic [19:0]          prev_q;
  logic [19:0]          aligned_data_q;
  logic                 aligned_valid_q;
  logic                 token_hit_q;

  logic [39:0] window;
  logic [39:0] shifted;
  logic [9:0]  s0, s1;
  logic        hit;

  function automatic logic is_token(input logic [9:0] sym);
    return (sym == 10'h354) || (sym == 10'h0ab) || (sym == 10'h154) || (sym == 10'h2ab);
  endfunction

  assign window  = {rx_parallel_data, prev_q};
  assign shifted = window >> offset_q;
  assign s0      = shifted[9:0];
  assign s1      = shifted[19:10];
  assign hit     = rx_data_valid && (is_token(s0) || is_token(s1));

  assign offset_next = (offset_q == 5'd19) ? 5'd0 : offset_q + 5'd1;

  always_comb begin
    state_d      = state_q;
    offset_d     = offset_q;
    search_cnt_d = search_cnt_q;
    hit_cnt_d    = hit_cnt_q;
    loss_cnt_d   = loss_cnt_q;
    if (rx_data_valid) begin
      unique case (state_q)
        StHunt: begin
          hit_cnt_d = hit ? hit_cnt_q + 8'd1 : 8'd0;
          // Reaching the lock count wins over a simultaneous search timeout.
          if (hit && (hit_cnt_q == LockLast)) begin
            state_d      = StLocked;
            search_cnt_d = '0;
            loss_cnt_d   = '0;
          end else if (search_cnt_q == SearchLast) begin
            offset_d     = offset_next;
            search_cnt_d = '0;
            hit_cnt_d    = '0;
          end else begin
            search_cnt_d = search_cnt_q + 1'b1;
          end
        end
        StLocked: begin
          if (hit) begin
            loss_cnt_d = '0;
          end else if (loss_cnt_q == LossLast) begin
            state_d      = StHunt;
            offset_d     = offset_next;
            search_cnt_d = '0;
            hit_cnt_d    = '0;
            loss_cnt_d   = '0;
          end else begin
            loss_cnt_d = loss_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rx_reset) begin
      state_q         <= StHunt;
      offset_q        <= '0;
      search_cnt_q    <= '0;
      hit_cnt_q       <= '0;
      loss_cnt_q      <= '0;
      prev_q          <= '0;
      aligned_data_q  <= '0;
      aligned_valid_q <= 1'b0;
      token_hit_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      offset_q        <= offset_d;
      search_cnt_q    <= search_cnt_d;
      hit_cnt_q       <= hit_cnt_d;
      loss_cnt_q      <= loss_cnt_d;
      aligned_valid_q <= rx_data_valid && (state_d == StLocked);
      if (rx_data_valid) begin
        prev_q         <= rx_parallel_data;
        aligned_data_q <= shifted[19:0];
        token_hit_q    <= hit;
      end
    end
  end

  assign aligned_data  = aligned_data_q;
  assign aligned_valid = aligned_valid_q;
  assign locked        = (state_q == StLocked);
  assign offset        = offset_q;
  assign token_hit     = token_hit_q;

endmodule

// File: tb/tb_hdmi_rx_word_align.sv
// Directed bench for hdmi_rx_word_align: hunt, lock, loss, bubbles and reset.
module tb_hdmi_rx_word_align;

  logic        rx_clk;
  logic        rx_reset;
  logic [19:0] rx_parallel_data;
  logic        rx_data_valid;
  logic [19:0] aligned_data;
  logic        aligned_valid;
  logic        locked;
  logic [4:0]  offset;
  logic        token_hit;

  int n_assert = 0;
  int n_fail   = 0;

  logic [19:0] w7;  // 0x354 stream, symbol boundary at window bit 7
  logic [19:0] v9;  // 0x354 stream, symbol boundary at window bit 9/19
  localparam logic [19:0] Fill = 20'h80000;

  hdmi_rx_word_align #(
    .SEARCH_CYCLES(16),
    .LOCK_COUNT   (8),
    .LOSS_CYCLES  (32)
  ) dut (
    .rx_clk          (rx_clk),
    .rx_reset        (rx_reset),
    .rx_parallel_data(rx_parallel_data),
    .rx_data_valid   (rx_data_valid),
    .aligned_data    (aligned_data),
    .aligned_valid   (aligned_valid),
    .locked          (locked),
    .offset          (offset),
    .token_hit       (token_hit)
  );

  initial rx_clk = 1'b0;
  always #5 rx_clk = ~rx_clk;

  function automatic logic [19:0] stream_word(input int boundary);
    logic [9:0]  sym;
    logic [19:0] word;
    sym = 10'h354;
    for (int i = 0; i < 20; i++) word[i] = sym[(i - boundary + 20) % 10];
    return word;
  endfunction

  task automatic step(input logic [19:0] d, input logic v);
    rx_parallel_data = d;
    rx_data_valid    = v;
    @(posedge rx_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    w7 = stream_word(7);
    v9 = stream_word(9);
    rx_reset = 1'b1;
    rx_parallel_data = '0;
    rx_data_valid = 1'b0;
    step(20'h0, 1'b0);
    step(20'h0, 1'b0);
    check("reset_outputs", 32'({aligned_data, aligned_valid, locked, offset, token_hit}), 32'h0);
    rx_reset = 1'b0;
    for (int c = 0; c < 100; c++) begin
      step(20'h0, 1'b0);
      check("idle_outputs", 32'({aligned_data, aligned_valid, locked, offset, token_hit}), 32'h0);
    end

    // Continuous stream: offsets 0..6 time out, lock at 7 on the 120th valid cycle.
    for (int n = 1; n <= 120; n++) begin
      step(w7, 1'b1);
      if (n == 16) check("offset_after_16", 32'(offset), 32'd1);
      if (n == 112) check("offset_after_112", 32'(offset), 32'd7);
      if (n == 119) check("unlocked_at_119", 32'(locked), 32'd0);
    end
    check("locked_at_120", 32'(locked), 32'd1);
    check("lock_offset", 32'(offset), 32'd7);
    check("lock_avalid", 32'(aligned_valid), 32'd1);
    check("lock_data", 32'(aligned_data), 32'hd5354);
    check("lock_token_hit", 32'(token_hit), 32'd1);

    // Reset pulse while locked, with valid data present.
    rx_reset = 1'b1;
    step(w7, 1'b1);
    rx_reset = 1'b0;
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_offset", 32'(offset), 32'd0);
    check("rst_avalid", 32'(aligned_valid), 32'd0);
    check("rst_data", 32'(aligned_data), 32'h0);

    // Relock, with a miss after 7 hits at offset 7; lock beats the timeout on the 16th.
    for (int n = 1; n <= 112; n++) step(w7, 1'b1);
    check("relock_offset", 32'(offset), 32'd7);
    check("relock_hunting", 32'(locked), 32'd0);
    for (int j = 0; j < 16; j++) begin
      step((j == 6) ? 20'h0 : w7, 1'b1);
      if (j == 7) begin
        check("miss_token_hit", 32'(token_hit), 32'd0);
        check("miss_no_lock", 32'(locked), 32'd0);
      end
      if (j == 14) check("seven_hits_no_lock", 32'(locked), 32'd0);
    end
    check("relock_priority", 32'(locked), 32'd1);
    check("relock_offset7", 32'(offset), 32'd7);

    // LOSS_CYCLES-1 misses then a hit: lock holds.
    step(Fill, 1'b1);
    check("fill_first_hit", 32'(token_hit), 32'd1);
    for (int n = 0; n < 31; n++) step(Fill, 1'b1);
    check("31_misses_locked", 32'(locked), 32'd1);
    check("31_misses_no_hit", 32'(token_hit), 32'd0);
    step(w7, 1'b1);
    check("rescue_hit", 32'(token_hit), 32'd1);
    check("rescue_locked", 32'(locked), 32'd1);
    check("rescue_data", 32'(aligned_data), 32'hd5000);

    // 32 misses unlock and advance offset 7 -> 8.
    step(Fill, 1'b1);
    for (int n = 1; n <= 32; n++) begin
      step(Fill, 1'b1);
      if (n == 31) check("loss_31_locked", 32'(locked), 32'd1);
    end
    check("loss_32_unlocked", 32'(locked), 32'd0);
    check("loss_32_avalid", 32'(aligned_valid), 32'd0);
    check("loss_offset8", 32'(offset), 32'd8);

    // Walk offsets 8..18 with no tokens, then lock at 19.
    for (int n = 1; n <= 176; n++) begin
      step(20'h0, 1'b1);
      if (n == 175) check("walk_offset18", 32'(offset), 32'd18);
    end
    check("walk_offset19", 32'(offset), 32'd19);
    for (int n = 1; n <= 8; n++) begin
      step(v9, 1'b1);
      if (n == 7) check("o19_not_yet", 32'(locked), 32'd0);
    end
    check("o19_locked", 32'(locked), 32'd1);
    check("o19_offset", 32'(offset), 32'd19);
    check("o19_data", 32'(aligned_data), 32'hd5354);
    for (int n = 1; n <= 32; n++) begin
      step(20'h0, 1'b1);
      if (n == 31) check("o19_loss_31", 32'(locked), 32'd1);
    end
    check("o19_loss_32", 32'(locked), 32'd0);
    check("o19_wrap", 32'(offset), 32'd0);

    // Alternating valid: garbage on bubbles must not disturb anything.
    rx_reset = 1'b1;
    step(20'h0, 1'b0);
    rx_reset = 1'b0;
    for (int c = 1; c <= 240; c++) begin
      if (c % 2 == 1) step(w7, 1'b1);
      else step(20'hfffff, 1'b0);
      if (c == 30) check("bubble_offset0", 32'(offset), 32'd0);
      if (c == 32) check("bubble_offset1", 32'(offset), 32'd1);
      if (c == 238) check("bubble_no_lock", 32'(locked), 32'd0);
      if (c == 239) begin
        check("bubble_locked", 32'(locked), 32'd1);
        check("bubble_avalid", 32'(aligned_valid), 32'd1);
        check("bubble_data", 32'(aligned_data), 32'hd5354);
      end
    end
    check("bubble_hold_locked", 32'(locked), 32'd1);
    check("bubble_hold_avalid", 32'(aligned_valid), 32'd0);
    check("bubble_hold_data", 32'(aligned_data), 32'hd5354);
    check("bubble_hold_offset", 32'(offset), 32'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hdmi_rx_word_align.md
# hdmi_rx_word_align

Per-lane TMDS word aligner for the HDMI receive path. It sits between the RX transceiver's 20-bit parallel output (two 10-bit TMDS symbols per `rx_clk`) and the TMDS decoder. It recovers symbol boundaries by searching the 20 possible bit offsets for TMDS control tokens, then declares lock and outputs boundary-aligned symbol pairs. It is the receive-side counterpart of the transmit transceiver's 20-bit-per-lane parallel interface; one instance is used per lane.

## Interface
Parameters:
- `SEARCH_CYCLES`, 4096: valid cycles spent at one offset before advancing (≥2).
- `LOCK_COUNT`, 8: consecutive valid hit cycles needed to lock (1..255).
- `LOSS_CYCLES`, 16384: valid cycles without a hit, while locked, that cause unlock (≥2).

Ports:
- `rx_clk`  in  1  recovered parallel clock; all logic on its rising edge.
- `rx_reset`  in  1  synchronous, active-high reset.
- `rx_parallel_data`  in  20  raw lane bits; bit 0 is the earliest received.
- `rx_data_valid`  in  1  qualifies `rx_parallel_data`.
- `aligned_data`  out  20  aligned symbols; [9:0] is the earlier symbol, [19:10] the later one.
- `aligned_valid`  out  1  `aligned_data` is valid and the aligner is locked.
- `locked`  out  1  alignment lock status.
- `offset`  out  5  current bit offset, 0..19.
- `token_hit`  out  1  a control token was found at the current offset on the last valid cycle.

## Operation
- `prev` register: holds the last valid input word. Window `w = {rx_parallel_data, prev}` (40 bits).
- Candidate symbols at offset k: `s0 = w[k+9:k]`, `s1 = w[k+19:k+10]`.
- A cycle is a hit when `rx_data_valid` is high and `s0` or `s1` is one of 0x354, 0x0AB, 0x154, 0x2AB.
- On a valid cycle:
  - `prev` loads the input.
  - `aligned_data` registers `w[offset+19:offset]`.
  - `token_hit` registers the hit flag.
- On a cycle with `rx_data_valid` low: `prev`, all counters, `aligned_data` and `token_hit` hold.
- Counters:
  - `search_cnt`: 0..SEARCH_CYCLES-1.
  - `hit_cnt`: 0..LOCK_COUNT, saturating.
  - `loss_cnt`: 0..LOSS_CYCLES-1.
- State HUNT (`locked` = 0), on each valid cycle:
  - Hit: `hit_cnt`+1. Non-hit: `hit_cnt` = 0.
  - If the hit makes `hit_cnt` reach LOCK_COUNT: go to LOCKED; clear `search_cnt` and `loss_cnt`; keep `offset`. This has priority over the search timeout.
  - Else if `search_cnt` = SEARCH_CYCLES-1: `offset` = (offset = 19) ? 0 : offset+1; clear `search_cnt` and `hit_cnt`.
  - Else `search_cnt`+1.
- State LOCKED (`locked` = 1), on each valid cycle:
  - Hit: `loss_cnt` = 0.
  - Non-hit with `loss_cnt` = LOSS_CYCLES-1: go to HUNT; advance `offset` with wrap 19→0; clear all counters.
  - Otherwise non-hit: `loss_cnt`+1.
- `aligned_valid` registers (`rx_data_valid` AND the state after this cycle's update is LOCKED).
- An offset change takes effect on the next valid cycle's window. Data already registered is not re-sliced.
- Reset values:
  - `offset` = 0, state HUNT, all counters 0, `prev` = 0.
  - `aligned_data` = 0, `aligned_valid` = 0, `locked` = 0, `token_hit` = 0.

## Timing
- Latency: input word at valid cycle t appears on `aligned_data` at cycle t+1. That output combines bits from t and the previous valid word.
- `locked` rises at the edge that registers the LOCK_COUNT-th consecutive hit, i.e. it is visible the cycle after that input.
- `aligned_valid` can first be high on that same edge.
- Unlock: `locked` and `aligned_valid` fall at the edge that registers the LOSS_CYCLES-th consecutive non-hit.
- `rx_reset` is sampled each edge. It overrides all other activity, including mid-lock and mid-search; outputs hold reset values the cycle after it is sampled.
- Deasserting `rx_data_valid` inserts bubbles only. Timeouts count valid cycles, not clock cycles.

## Test plan
- Reset with `rx_data_valid` held low → all outputs 0 and `offset` = 0; they stay 0 for 100 cycles.
- SEARCH_CYCLES=16, LOCK_COUNT=8, continuous repeating 0x354 stream with its boundary at window bit 7:
  - offsets 0..6 each time out after 16 cycles;
  - `locked` is high with `offset` = 7 after the 120th valid cycle;
  - `aligned_data` = {0x354, 0x354} thereafter.
- Locked at offset 7, then 7 hit cycles followed by one non-token cycle in HUNT → `hit_cnt` clears and no lock occurs. In the locked state, a LOSS_CYCLES-1 hit-free run followed by a hit → `locked` stays 1.
- LOSS_CYCLES=32, locked at offset 19, then random non-token data for 32 valid cycles → `locked` falls on the 32nd; `offset` wraps to 0.
- `rx_data_valid` toggling 1,0,1,0 during hunt → counters advance only on valid cycles; lock is reached after twice the clock cycles of the continuous case.
- `rx_reset` pulsed for 1 cycle while locked → next cycle `locked` = 0, `offset` = 0, `aligned_valid` = 0; the aligner relocks normally afterwards.
